// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: single-cycle ADD/SUB, shift-add MUL and restoring DIV.
// The result is registered and held until the next accepted operation completes.
module alu_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div0
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_next;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH:0]   acc;
    logic [CW-1:0]      cnt;

    logic               last_step;
    logic               div_by_zero;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH:0]   div_next;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] final_result;

    // a_q doubles as the multiplier (shifted right) or dividend (shifted left) during iteration
    always_comb begin
        div_by_zero = (b_q == '0);
        mul_sum     = acc[2*WIDTH:WIDTH] + (a_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_next    = {1'b0, mul_sum, acc[WIDTH-1:1]};
        rem_shift   = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_diff    = {1'b0, rem_shift} - {2'b00, b_q};
        if (div_diff[WIDTH+1])
            div_next = {rem_shift, acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
        add_sum  = {1'b0, a_q} + {1'b0, b_q};
        sub_diff = {1'b0, a_q} - {1'b0, b_q};

        final_result = '0;
        case (op_q)
            OP_ADD: final_result = {{(WIDTH-1){1'b0}}, add_sum};
            OP_SUB: final_result = {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
            OP_MUL: final_result = mul_next[2*WIDTH-1:0];
            OP_DIV: final_result = div_by_zero ? {a_q, {WIDTH{1'b1}}} : div_next[2*WIDTH-1:0];
            default: final_result = '0;
        endcase

        last_step = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                    ((op_q == OP_DIV) && div_by_zero) || (cnt == CW'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = EXEC;
            EXEC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            div0   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
                acc  <= '0;
                cnt  <= CW'(WIDTH);
            end else if (state == EXEC) begin
                if (op_q == OP_MUL) begin
                    acc <= mul_next;
                    a_q <= a_q >> 1;
                    cnt <= cnt - CW'(1);
                end else if (op_q == OP_DIV && !div_by_zero) begin
                    acc <= div_next;
                    a_q <= a_q << 1;
                    cnt <= cnt - CW'(1);
                end
                if (last_step) begin
                    result <= final_result;
                    div0   <= (op_q == OP_DIV) && div_by_zero;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: expected results are queued at stimulus time
// from a behavioural model and popped when the done pulse arrives.
module tb_alu_seq_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           div0;

    typedef struct {
        logic [15:0] res;
        logic        dz;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] last_result = '0;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .div0   (div0)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t modelOp(input logic [1:0] o, input int x, input int y, input string tag);
        exp_t e;
        e.tag = tag;
        e.dz  = 1'b0;
        e.lat = 1;
        e.res = '0;
        case (o)
            2'b00: e.res = 16'(x + y);
            2'b01: e.res = 16'(x - y);
            2'b10: begin e.res = 16'(x * y); e.lat = W; end
            default: begin
                if (y == 0) begin
                    e.res = 16'((x << 8) | 255);
                    e.dz  = 1'b1;
                end else begin
                    e.res = 16'(((x % y) << 8) | (x / y));
                    e.lat = W;
                end
            end
        endcase
        return e;
    endfunction

    // Drives one request on a falling edge; returns 1 time unit after the accepting edge
    task automatic applyStimulus(input logic [1:0] o, input int x, input int y,
                                 input string tag, input bit hold);
        sbq.push_back(modelOp(o, x, y, tag));
        @(negedge clk);
        op    = o;
        a     = W'(x);
        b     = W'(y);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic waitResult();
        exp_t item;
        int   cyc;
        item = sbq.pop_front();
        for (cyc = 0; cyc < 40; cyc++) begin
            if (done === 1'b1) break;
            checkOutput({item.tag, "_busy_exec"}, 32'(busy), 32'd1);
            checkOutput({item.tag, "_result_held"}, 32'(result), 32'(last_result));
            @(posedge clk);
            #1;
        end
        checkOutput({item.tag, "_done"}, 32'(done), 32'd1);
        checkOutput({item.tag, "_latency"}, 32'(cyc), 32'(item.lat));
        checkOutput({item.tag, "_result"}, 32'(result), 32'(item.res));
        checkOutput({item.tag, "_div0"}, 32'(div0), 32'(item.dz));
        checkOutput({item.tag, "_busy_done"}, 32'(busy), 32'd1);
        last_result = item.res;
        @(posedge clk);
        #1;
        checkOutput({item.tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({item.tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_div0", 32'(div0), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(2'b00, 200, 100, "add_200_100", 1'b0);
        waitResult();
        applyStimulus(2'b01, 3, 5, "sub_3_5", 1'b0);
        waitResult();
        applyStimulus(2'b01, 5, 3, "sub_5_3", 1'b0);
        waitResult();
        applyStimulus(2'b10, 255, 255, "mul_255_255", 1'b0);
        waitResult();
        applyStimulus(2'b10, 0, 77, "mul_0_77", 1'b0);
        waitResult();
        applyStimulus(2'b11, 200, 7, "div_200_7", 1'b0);
        waitResult();
        applyStimulus(2'b11, 5, 0, "div_5_0", 1'b0);
        waitResult();
        applyStimulus(2'b00, 1, 1, "add_1_1", 1'b0);
        waitResult();

        // start held high while the inputs change under a running MUL
        applyStimulus(2'b10, 10, 10, "mul_hold", 1'b1);
        op = 2'b00;
        a  = 8'd3;
        b  = 8'd4;
        waitResult();
        sbq.push_back(modelOp(2'b00, 3, 4, "add_after_hold"));
        @(posedge clk);
        #1;
        start = 1'b0;
        waitResult();

        // asynchronous reset in the middle of a MUL
        applyStimulus(2'b10, 12, 13, "mul_abort", 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("abort_busy_now", 32'(busy), 32'd0);
        checkOutput("abort_done_now", 32'(done), 32'd0);
        checkOutput("abort_result_now", 32'(result), 32'd0);
        checkOutput("abort_div0_now", 32'(div0), 32'd0);
        sbq.delete();
        last_result = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_done", 32'(done), 32'd0);
            checkOutput("abort_no_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(2'b11, 9, 2, "div_9_2", 1'b0);
        waitResult();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle ALU sequencer for the 8-bit operand/register datapath. It accepts one operation per start handshake and runs it to completion with internal operand, accumulator and counter registers. ADD/SUB complete in a single execute cycle. MUL uses iterative shift-add and DIV uses restoring division, one bit per cycle. It provides busy/done status to the host controller and holds the 2*WIDTH result until the next accepted operation.

Parameters:
WIDTH, 8, operand width in bits; result is 2*WIDTH; iteration count for MUL/DIV is WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (rst=0 resets immediately, independent of clk)
start  input  1  request strobe; sampled only in IDLE
op  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV (unsigned)
a  input  WIDTH  operand A, captured on accepting edge
b  input  WIDTH  operand B, captured on accepting edge
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse (state == DONE)
result  output  2*WIDTH  registered result, held between operations
div0  output  1  set with result when DIV had b == 0, cleared on any other completion

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, result=0, div0=0; internal A, B, ACC and counter cleared. Reset asserted mid-operation aborts it; no done pulse is produced.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE: if start=1 at a rising edge (E0): latch a, b and op; clear ACC; cnt=WIDTH; go to EXEC. Otherwise stay in IDLE.
- start is ignored in EXEC and DONE, whatever its value. Input changes after E0 have no effect.
- EXEC, ADD: at E1, result = zero-extended a+b (carry in bit WIDTH); go to DONE.
- EXEC, SUB: at E1, result = a-b as a 2*WIDTH two's-complement value (sign-extended from WIDTH+1 bits); go to DONE.
- EXEC, MUL: each edge adds B to ACC's upper half if the multiplier LSB is 1, then shifts right one bit; cnt decrements. At the edge where cnt reaches 0 (E_WIDTH): result = a*b; go to DONE.
- EXEC, DIV with b != 0: each edge shifts {rem, quot} left one bit, trial-subtracts B, restores on negative and sets the quotient bit otherwise. At E_WIDTH: result = {remainder, quotient}; go to DONE.
- EXEC, DIV with b == 0: no iterations. At E1: result = {a, all-ones}, div0=1; go to DONE.
- result and div0 change only on the EXEC->DONE edge and on reset.
- DONE: done=1 and busy=1 for exactly one cycle; unconditional transition to IDLE.
- Latency (accepting edge E0 to done high):
  - ADD, SUB, DIV-by-0: done high after E1.
  - MUL, DIV: done high after E_WIDTH.
- Back-to-back: minimum gap between accepting edges is latency+2 cycles (EXEC..DONE, then IDLE samples start).
- Arithmetic: all unsigned except the SUB result encoding. ACC is 2*WIDTH+1 bits internally, so there is no overflow loss.

Test Plan:
1. ADD a=200, b=100, start 1 cycle -> result=16'h012C, done pulses one cycle after E1, busy high 2 cycles, div0=0.
2. SUB a=3, b=5 -> result=16'hFFFE. SUB a=5, b=3 -> result=16'h0002.
3. MUL a=255, b=255 -> result=16'hFE01, done high exactly after E8. MUL a=0, b=77 -> 16'h0000 with the same latency.
4. DIV a=200, b=7 -> result=16'h041C (rem 4, quot 28), done after E8. DIV a=5, b=0 -> result=16'h05FF, div0=1 after E1; a following ADD 1+1 -> 16'h0002, div0=0.
5. Start a MUL 10*10, hold start high with a, b and op changing during EXEC -> result=16'h0064 with no extra operation. start high in the DONE cycle is ignored; the same start is accepted the next cycle in IDLE.
6. Drive rst=0 between edges during MUL iteration 4 -> busy, done and result go to 0 immediately, with no done pulse. After releasing rst, DIV 9/2 -> 16'h0104.
